seven_seg_scan_3: RTL and testbench

Three-digit multiplexed seven-segment driver that sits directly downstream of the board's BCD counters. It latches three BCD digits plus decimal points, then scans them onto the Mimas V2 common-anode display. Segments and digit enables are active-low. Frame-synchronous commit prevents tearing, and a dead gap between digits suppresses ghosting.

---
 rtl/seven_seg_scan_3_if.sv | 25 ++
 rtl/seven_seg_scan_3.sv | 197 +++++++++++++++++++
 tb/tb_seven_seg_scan_3.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_3_if.sv
// Signal bundle between the BCD counter side and the multiplexed
// seven-segment driver. The master drives digits and strobes. The slave
// (the driver) returns the active-low display lines.
interface seven_seg_scan_3_if;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [2:0] dp_in;
  logic       lz_blank;
  logic       load;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [2:0] en_n;
  logic       frame_done;

  modport master (
    output bcd0, bcd1, bcd2, dp_in, lz_blank, load,
    input  seg_n, dp_n, en_n, frame_done
  );

  modport slave (
    input  bcd0, bcd1, bcd2, dp_in, lz_blank, load,
    output seg_n, dp_n, en_n, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_3.sv
// Three-digit multiplexed seven-segment driver for a common-anode display.
// Digits are captured into a pending buffer on load. They are committed to
// the display registers only at the frame boundary, so a frame never tears.
// Each digit slot ends with a gap in which all enables are off, which
// suppresses ghosting between digits.
//
// state | meaning
// ------+--------------------------------------------
// DIG0  | scanning slot 0 (units, rightmost digit)
// DIG1  | scanning slot 1 (tens)
// DIG2  | scanning slot 2 (hundreds, leftmost); its last cycle is the frame boundary
module seven_seg_scan_3 #(
  parameter int SCAN_DIV = 100000,
  parameter int GAP_CYC  = 1000
) (
  input logic                clk,
  input logic                reset,
  seven_seg_scan_3_if.slave  bus
);

  localparam int             CW    = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  TC_LD = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  GAP_V = CW'(GAP_CYC);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2
  } dig_t;

  dig_t state;
  dig_t state_nxt;

  // The slot timer counts down from SCAN_DIV-1. A remaining count of r
  // corresponds to slot position SCAN_DIV-1-r. The slot is ACTIVE while
  // r >= GAP_CYC, and the slot ends at terminal count 0.
  logic [CW-1:0] tmr;
  logic          tc;
  logic          active;
  logic          boundary;

  logic [3:0] disp_d0, disp_d1, disp_d2;
  logic [2:0] disp_dp;
  logic [3:0] pend_d0, pend_d1, pend_d2;
  logic [2:0] pend_dp;
  logic       pend_v;

  logic       blank1, blank2;
  logic [3:0] cur_bcd;
  logic       cur_dp;
  logic       cur_blank;
  logic [2:0] en_pat;
  logic       bnd_q;

  assign tc       = (tmr == '0);
  assign active   = (tmr >= GAP_V);
  assign boundary = tc && (state == DIG2);

  // Leading-zero blanking uses the live lz_blank. A blank ripples right
  // from the hundreds digit and stops at the units digit.
  assign blank2 = bus.lz_blank && (disp_d2 == 4'd0);
  assign blank1 = blank2 && (disp_d1 == 4'd0);

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Slot timer: reload at terminal count, otherwise count down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr <= TC_LD;
    end else if (tc) begin
      tmr <= TC_LD;
    end else begin
      tmr <= tmr - CW'(1);
    end
  end

  // Digit FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DIG0;
    end else begin
      state <= state_nxt;
    end
  end

  // Digit FSM next state plus the per-slot digit, DP, blank and enable selection.
  always_comb begin
    state_nxt = state;
    cur_bcd   = disp_d0;
    cur_dp    = disp_dp[0];
    cur_blank = 1'b0;
    en_pat    = 3'b001;
    unique case (state)
      DIG0: begin
        if (tc) state_nxt = DIG1;
      end
      DIG1: begin
        if (tc) state_nxt = DIG2;
        cur_bcd   = disp_d1;
        cur_dp    = disp_dp[1];
        cur_blank = blank1;
        en_pat    = 3'b010;
      end
      DIG2: begin
        if (tc) state_nxt = DIG0;
        cur_bcd   = disp_d2;
        cur_dp    = disp_dp[2];
        cur_blank = blank2;
        en_pat    = 3'b100;
      end
      default: begin
        state_nxt = DIG0;
      end
    endcase
  end

  // Capture into the pending buffer (last load wins) and commit at the frame
  // boundary. A load in the boundary cycle bypasses the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_d0 <= '0;
      pend_d1 <= '0;
      pend_d2 <= '0;
      pend_dp <= '0;
      pend_v  <= 1'b0;
      disp_d0 <= '0;
      disp_d1 <= '0;
      disp_d2 <= '0;
      disp_dp <= '0;
    end else if (boundary) begin
      pend_v <= 1'b0;
      if (bus.load) begin
        disp_d0 <= bus.bcd0;
        disp_d1 <= bus.bcd1;
        disp_d2 <= bus.bcd2;
        disp_dp <= bus.dp_in;
      end else if (pend_v) begin
        disp_d0 <= pend_d0;
        disp_d1 <= pend_d1;
        disp_d2 <= pend_d2;
        disp_dp <= pend_dp;
      end
    end else if (bus.load) begin
      pend_d0 <= bus.bcd0;
      pend_d1 <= bus.bcd1;
      pend_d2 <= bus.bcd2;
      pend_dp <= bus.dp_in;
      pend_v  <= 1'b1;
    end
  end

  // Delay the boundary by one cycle. frame_done then lines up with the
  // first output cycle that shows the committed digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bnd_q <= 1'b0;
    end else begin
      bnd_q <= boundary;
    end
  end

  // Registered display outputs. Segments keep showing the current digit
  // through the gap, and only the enables are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.seg_n      <= SEG_BLANK;
      bus.dp_n       <= 1'b1;
      bus.en_n       <= 3'b111;
      bus.frame_done <= 1'b0;
    end else begin
      bus.seg_n      <= cur_blank ? SEG_BLANK : seg_decode(cur_bcd);
      bus.dp_n       <= ~cur_dp;
      bus.en_n       <= active ? ~en_pat : 3'b111;
      bus.frame_done <= bnd_q;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_3.sv
// Directed bench for seven_seg_scan_3 with SCAN_DIV=8, GAP_CYC=2.
// The variable t is the state index currently visible on the outputs.
// Slot s, cycle c of frame f is visible at t = 24*f + 8*s + c.
// A load driven at negedge t is seen by the DUT while its internal state is t+1.
module tb_seven_seg_scan_3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   t;
  int   checks = 0;
  int   errors = 0;

  seven_seg_scan_3_if bus ();

  seven_seg_scan_3 #(.SCAN_DIV(8), .GAP_CYC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic set_digits(input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0, input logic [2:0] dp);
    bus.bcd2  = d2;
    bus.bcd1  = d1;
    bus.bcd0  = d0;
    bus.dp_in = dp;
  endtask

  initial begin
    bus.load     = 1'b0;
    bus.lz_blank = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 3'b000);
    t = -1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(bus.seg_n), 32'h7F);
    chk("rst_dp", 32'(bus.dp_n), 32'h1);
    chk("rst_en", 32'(bus.en_n), 32'h7);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    reset = 1'b1;
    t = -1;

    // 1: blank display, lz on, scan timing and the first frame_done
    goto(0);
    chk("s1_en_t0", 32'(bus.en_n), 32'h6);
    chk("s1_seg_t0", 32'(bus.seg_n), 32'h40);
    chk("s1_dp_t0", 32'(bus.dp_n), 32'h1);
    goto(5);  chk("s1_en_t5", 32'(bus.en_n), 32'h6);
    goto(6);  chk("s1_gap_t6", 32'(bus.en_n), 32'h7);
    goto(7);  chk("s1_gap_t7", 32'(bus.en_n), 32'h7);
    goto(8);  chk("s1_en_t8", 32'(bus.en_n), 32'h5);
    chk("s1_seg_t8", 32'(bus.seg_n), 32'h7F);
    goto(15); chk("s1_gap_t15", 32'(bus.en_n), 32'h7);
    goto(16); chk("s1_en_t16", 32'(bus.en_n), 32'h3);
    chk("s1_seg_t16", 32'(bus.seg_n), 32'h7F);
    goto(22); chk("s1_fd_t22", 32'(bus.frame_done), 32'h0);
    goto(23); chk("s1_fd_t23", 32'(bus.frame_done), 32'h0);
    chk("s1_gap_t23", 32'(bus.en_n), 32'h7);
    goto(24); chk("s1_fd_t24", 32'(bus.frame_done), 32'h1);
    goto(25); chk("s1_fd_t25", 32'(bus.frame_done), 32'h0);

    // 2: load 1/2/3 with dp=010 at frame cycle 5, visible from the next frame
    goto(28);
    set_digits(4'd1, 4'd2, 4'd3, 3'b010);
    bus.load = 1'b1;
    goto(29);
    bus.load = 1'b0;
    goto(32); chk("s2_old_s1", 32'(bus.seg_n), 32'h7F);
    chk("s2_old_dp1", 32'(bus.dp_n), 32'h1);
    goto(40); chk("s2_old_s2", 32'(bus.seg_n), 32'h7F);
    goto(48); chk("s2_s0_seg", 32'(bus.seg_n), 32'h30);
    chk("s2_s0_en", 32'(bus.en_n), 32'h6);
    goto(56); chk("s2_s1_seg", 32'(bus.seg_n), 32'h24);
    chk("s2_s1_dp", 32'(bus.dp_n), 32'h0);
    goto(64); chk("s2_s2_seg", 32'(bus.seg_n), 32'h79);
    chk("s2_s2_dp", 32'(bus.dp_n), 32'h1);

    // 3: two loads in one frame, the last one wins
    goto(74);
    set_digits(4'd4, 4'd5, 4'd6, 3'b000);
    bus.load = 1'b1;
    goto(75);
    bus.load = 1'b0;
    goto(80);
    set_digits(4'd7, 4'd8, 4'd9, 3'b000);
    bus.load = 1'b1;
    goto(81);
    bus.load = 1'b0;
    goto(88);  chk("s3_cur_s2", 32'(bus.seg_n), 32'h79);
    goto(96);  chk("s3_s0_seg", 32'(bus.seg_n), 32'h10);
    goto(104); chk("s3_s1_seg", 32'(bus.seg_n), 32'h00);
    chk("s3_s1_dp", 32'(bus.dp_n), 32'h1);
    goto(112); chk("s3_s2_seg", 32'(bus.seg_n), 32'h78);

    // 4: 3/3/3 is left pending, then 0/0/5 dp=100 is loaded in the boundary cycle
    goto(100);
    set_digits(4'd3, 4'd3, 4'd3, 3'b000);
    bus.load = 1'b1;
    goto(101);
    bus.load = 1'b0;
    goto(118);
    set_digits(4'd0, 4'd0, 4'd5, 3'b100);
    bus.load = 1'b1;
    goto(119);
    bus.load = 1'b0;
    goto(120); chk("s4_s0_seg", 32'(bus.seg_n), 32'h12);
    chk("s4_fd", 32'(bus.frame_done), 32'h1);
    goto(128); chk("s4_s1_blank", 32'(bus.seg_n), 32'h7F);
    chk("s4_s1_en", 32'(bus.en_n), 32'h5);
    goto(136); chk("s4_s2_blank", 32'(bus.seg_n), 32'h7F);
    chk("s4_s2_dp", 32'(bus.dp_n), 32'h0);
    goto(140);
    bus.lz_blank = 1'b0;
    goto(144); chk("s4_nopend_s0", 32'(bus.seg_n), 32'h12);
    goto(152); chk("s4_lz0_s1", 32'(bus.seg_n), 32'h40);
    goto(160); chk("s4_lz0_s2", 32'(bus.seg_n), 32'h40);
    chk("s4_lz0_dp2", 32'(bus.dp_n), 32'h0);

    // 5: dash codes C and F with DPs on digits 0 and 2
    goto(164);
    set_digits(4'hF, 4'd0, 4'hC, 3'b101);
    bus.load = 1'b1;
    goto(165);
    bus.load = 1'b0;
    goto(168); chk("s5_s0_dash", 32'(bus.seg_n), 32'h3F);
    chk("s5_s0_dp", 32'(bus.dp_n), 32'h0);
    goto(176); chk("s5_s1_seg", 32'(bus.seg_n), 32'h40);
    chk("s5_s1_dp", 32'(bus.dp_n), 32'h1);
    goto(184); chk("s5_s2_dash", 32'(bus.seg_n), 32'h3F);
    chk("s5_s2_dp", 32'(bus.dp_n), 32'h0);

    // 6: reset in slot 1 with a load pending, and the pending value is lost
    goto(194);
    set_digits(4'd9, 4'd9, 4'd9, 3'b000);
    bus.load = 1'b1;
    goto(195);
    bus.load = 1'b0;
    goto(201); chk("s6_pre_en", 32'(bus.en_n), 32'h5);
    reset = 1'b0;
    #1;
    chk("s6_async_en", 32'(bus.en_n), 32'h7);
    chk("s6_async_seg", 32'(bus.seg_n), 32'h7F);
    chk("s6_async_dp", 32'(bus.dp_n), 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    t = -1;
    goto(0);  chk("s6_restart_en", 32'(bus.en_n), 32'h6);
    chk("s6_restart_seg", 32'(bus.seg_n), 32'h40);
    goto(24); chk("s6_f1_s0", 32'(bus.seg_n), 32'h40);
    goto(32); chk("s6_f1_s1", 32'(bus.seg_n), 32'h40);
    goto(40); chk("s6_f1_s2", 32'(bus.seg_n), 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
